dmem_arbiter: RTL
=================

# dmem_arbiter

Round-robin arbiter that shares the single-port 16-bit data memory between the processor cores of the multicore design. It accepts one outstanding request per core, serialises accesses onto the data RAM's control and data lines (WR, RD, ADDBUS, DATAIN, DATAOUT), and returns a one-cycle acknowledge plus read data to the winning core. It sits between the per-core memory stages and the shared data RAM instance.

## Interface

- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, address width, passed to the RAM unchanged
- DATA_W, 16, data word width

- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  NUM_CORES  per-core request, held high until that core's ack
- core_wr  in  NUM_CORES  per-core access type, 1 = write, 0 = read; stable while req is high
- core_addr  in  NUM_CORES*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  packed write data, same packing
- core_ack  out  NUM_CORES  one-hot, one-cycle completion pulse
- core_rdata  out  DATA_W  shared read-data bus, valid only while the matching core_ack bit is high
- mem_addr  out  ADDR_W  to RAM ADDBUS
- mem_wdata  out  DATA_W  to RAM DATAIN
- mem_wr  out  1  to RAM WR
- mem_rd  out  1  to RAM RD
- mem_rdata  in  DATA_W  from RAM DATAOUT; high-Z when mem_rd is low

## Operation

- FSM states: IDLE, ACCESS, RESP. Every transaction is IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: if any core_req bit is high, select the winner by round-robin:
  - The first requesting index after last_grant, in the order last_grant+1, +2, ... modulo NUM_CORES.
  - Latch winner index, core_wr, core_addr and core_wdata of the winner; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wdata come from the latched values; mem_wr = latched wr; mem_rd = !latched wr.
  - All mem_* outputs are registered, so they are stable for the whole ACCESS cycle.
  - Write: the RAM commits at the rising edge ending ACCESS.
  - Read: mem_rdata is captured into an internal register at that same edge.
  - Go to RESP.
- RESP (exactly one cycle):
  - core_ack[winner] = 1; core_rdata = captured read data. Writes drive the last captured value, which is don't-care for the core.
  - mem_wr = mem_rd = 0.
  - last_grant := winner; go to IDLE.
- Outside ACCESS: mem_wr = mem_rd = 0; mem_addr and mem_wdata hold their last value.
- Outside RESP: core_ack = 0.
- Requests present in ACCESS or RESP are not sampled; they are arbitrated at the next IDLE.
- A core dropping req during ACCESS or RESP does not cancel its transaction: the ack still fires.
- A core that keeps req high after its ack is treated as issuing a new request.
- Starvation bound: a continuously requesting core is served within NUM_CORES transactions (3*NUM_CORES cycles).

## Timing

- Reset values: state = IDLE, last_grant = NUM_CORES-1 (so core 0 has first priority), core_ack = 0, core_rdata = 0, mem_wr = 0, mem_rd = 0, mem_addr = 0, mem_wdata = 0, captured data = 0.
- Latency: req high in cycle n with the FSM in IDLE gives ACCESS in n+1 and ack in n+2.
- Throughput: one access per 3 cycles; the earliest next ACCESS is n+4.
- Reset mid-operation:
  - rst sampled high in any state forces the reset values at that edge, and no ack is issued.
  - A write whose ACCESS cycle coincides with rst high is still committed by the RAM, because mem_wr was already high in that cycle.
- mem_rdata is only sampled at the edge ending a read ACCESS; Z at any other time is harmless.

## Test plan

- Single read: preload RAM[5] = 0x00AA; core 1 reads addr 5 in cycle 0 -> mem_rd = 1 in cycle 1, core_ack = 4'b0010 and core_rdata = 0x00AA in cycle 2, idle in cycle 3.
- Write then read: core 2 writes 0x1234 to addr 9, then core 0 reads addr 9 -> core 0 gets ack with core_rdata = 0x1234; RAM[9] = 0x1234.
- Round-robin fairness: all four cores request continuously from reset -> acks in order 0,1,2,3,0,... spaced 3 cycles apart; no core is skipped.
- Rotation from mid-point: last_grant = 1; cores 0 and 3 request together -> core 3 is served first, then core 0.
- Reset during ACCESS: core 0 writes 0x5555 to addr 3 with rst high in the ACCESS cycle -> no ack, FSM in IDLE next cycle, all outputs at reset values, RAM[3] = 0x5555.
- Request dropped early: core 1 drops req during ACCESS -> its ack still pulses in RESP, and no second transaction is started for core 1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data RAM
// between NUM_CORES cores. Each transaction is IDLE -> ACCESS -> RESP.
// All RAM-side and core-side outputs are registered.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   core_req        per-core request, held until that core's ack
//   core_wr         per-core access type (1 = write)
//   core_addr       packed addresses, core i at [i*ADDR_W +: ADDR_W]
//   core_wdata      packed write data, same packing
//   core_ack        one-hot, one-cycle completion pulse (RESP)
//   core_rdata      read data, valid while the matching ack bit is high
//   mem_addr/wdata  to RAM ADDBUS/DATAIN; hold their value outside ACCESS
//   mem_wr/mem_rd   to RAM WR/RD; high only in ACCESS
//   mem_rdata       from RAM DATAOUT; sampled only at the end of a read ACCESS
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_wr,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wr,
  output logic                        mem_rd,
  input  logic [DATA_W-1:0]           mem_rdata
);
  localparam int IW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last_grant, win, pick;
  logic          any_req;

  logic [NUM_CORES-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_CORES-1:0][DATA_W-1:0] wdata_v;

  genvar g;
  generate
    for (g = 0; g < NUM_CORES; g++) begin : g_unpack
      assign addr_v[g]  = core_addr[g*ADDR_W +: ADDR_W];
      assign wdata_v[g] = core_wdata[g*DATA_W +: DATA_W];
    end
  endgenerate

  assign any_req = |core_req;

  // Scan from the farthest candidate back to last_grant+1 so the nearest
  // requester after last_grant overwrites the others and wins.
  always_comb begin : rr_pick
    int            t;
    logic [IW-1:0] idx;
    pick = last_grant;
    t    = 0;
    idx  = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      t = int'(last_grant) + k;
      if (t >= NUM_CORES) t = t - NUM_CORES;
      idx = IW'(t);
      if (core_req[idx]) pick = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_wr doubles as the latched access type; the address/data registers
  // are only loaded on a grant, so they hold their last value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IW'(NUM_CORES - 1);
      win        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      core_ack   <= '0;
      core_rdata <= '0;
    end else begin
      mem_wr   <= 1'b0;
      mem_rd   <= 1'b0;
      core_ack <= '0;
      case (state)
        IDLE: if (any_req) begin
          win       <= pick;
          mem_addr  <= addr_v[pick];
          mem_wdata <= wdata_v[pick];
          mem_wr    <= core_wr[pick];
          mem_rd    <= !core_wr[pick];
        end
        ACCESS: begin
          if (mem_rd) core_rdata <= mem_rdata;
          core_ack[win] <= 1'b1;
        end
        RESP:    last_grant <= win;
        default: ;
      endcase
    end
  end
endmodule
